// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared encodings and widths for the hms timekeeper
package hms_pkg;

    // Operating modes on i_mode; MODE_RSVD behaves exactly like MODE_CLOCK.
    localparam logic [1:0] MODE_CLOCK     = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;
    localparam logic [1:0] MODE_RSVD      = 2'd3;

    // Field selects on i_pos.
    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;
    localparam logic [1:0] POS_NONE = 2'd3;

    // Field widths; minutes share the seconds width.
    localparam int SEC_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    // Ring FSM state.
    typedef logic [0:0] ring_state_t;
    localparam ring_state_t RING_IDLE   = 1'b0;
    localparam ring_state_t RING_ACTIVE = 1'b1;

endpackage

// File: rtl/hms_field.sv
// rtl/hms_field.sv - wrap counter for one time or alarm field
//
// Ports: clk/rst (sync, active-high), max_val (wrap value), inc/dec (edit
// pulses, ignored when both set), cin (carry-in advance, wins over edits),
// clr (load zero), q (field value), cout (cin while q==max_val).
module hms_field #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] max_val,
    input  logic         inc,
    input  logic         dec,
    input  logic         cin,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         cout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (cin || (inc && !dec)) begin
            q <= (q == max_val) ? '0 : q + W'(1);
        end else if (dec && !inc) begin
            q <= (q == '0) ? max_val : q - W'(1);
        end
    end

    // Carry only ripples on a real advance, never on a manual edit.
    assign cout = cin && (q == max_val);

endmodule

// File: rtl/hms_timekeeper.sv
// rtl/hms_timekeeper.sv - HH:MM:SS timekeeper with N alarms and ring control
//
// Ports: clk/rst (sync, active-high); i_mode/i_pos/i_alarm_sel/i_inc/i_dec
// edit controls; i_alarm_en per-alarm enable; i_stop ring acknowledge;
// o_sec/o_min/o_hour display (time or selected alarm); o_tick/o_day_wrap
// one-cycle pulses; o_ring/o_ring_id buzzer enable and ringing alarm index.
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int HOUR_MAX   = 23,
    parameter int NUM_ALARMS = 2,
    parameter int RING_SEC   = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_mode,
    input  logic [1:0]            i_pos,
    input  logic [1:0]            i_alarm_sel,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic [NUM_ALARMS-1:0] i_alarm_en,
    input  logic                  i_stop,
    output logic [SEC_W-1:0]      o_sec,
    output logic [SEC_W-1:0]      o_min,
    output logic [HOUR_W-1:0]     o_hour,
    output logic                  o_tick,
    output logic                  o_day_wrap,
    output logic                  o_ring,
    output logic [1:0]            o_ring_id
);

    localparam int PS_W = $clog2(CLK_HZ);
    localparam int RC_W = $clog2(RING_SEC) + 1;
    localparam logic [HOUR_W-1:0] HOUR_TOP = HOUR_W'(HOUR_MAX);

    logic in_set_time;
    logic in_set_alarm;

    always_comb begin
        in_set_time  = 1'b0;
        in_set_alarm = 1'b0;
        case (i_mode)
            MODE_SET_TIME:         in_set_time  = 1'b1;
            MODE_SET_ALARM:        in_set_alarm = 1'b1;
            MODE_CLOCK, MODE_RSVD: ;
        endcase
    end

    // Edit pulses after cancelling simultaneous inc+dec and the "none" field.
    logic edit_inc;
    logic edit_dec;
    assign edit_inc = i_inc && !i_dec && (i_pos != POS_NONE);
    assign edit_dec = i_dec && !i_inc && (i_pos != POS_NONE);

    // Prescaler: held at zero while setting time, so leaving SET_TIME
    // always begins a complete second.
    logic [PS_W-1:0] presc;
    logic            tick_now;
    assign tick_now = !in_set_time && (presc == PS_W'(CLK_HZ - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (in_set_time || tick_now) begin
            presc <= '0;
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    // Current time.
    logic [SEC_W-1:0]  t_sec;
    logic [SEC_W-1:0]  t_min;
    logic [HOUR_W-1:0] t_hour;
    logic              sec_co;
    logic              min_co;
    logic              hour_co;

    hms_field #(.W(SEC_W)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .max_val (SEC_MAX),
        .inc     (in_set_time && edit_inc && (i_pos == POS_SEC)),
        .dec     (in_set_time && edit_dec && (i_pos == POS_SEC)),
        .cin     (tick_now),
        .clr     (1'b0),
        .q       (t_sec),
        .cout    (sec_co)
    );

    hms_field #(.W(SEC_W)) u_min (
        .clk     (clk),
        .rst     (rst),
        .max_val (SEC_MAX),
        .inc     (in_set_time && edit_inc && (i_pos == POS_MIN)),
        .dec     (in_set_time && edit_dec && (i_pos == POS_MIN)),
        .cin     (sec_co),
        .clr     (1'b0),
        .q       (t_min),
        .cout    (min_co)
    );

    hms_field #(.W(HOUR_W)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .max_val (HOUR_TOP),
        .inc     (in_set_time && edit_inc && (i_pos == POS_HOUR)),
        .dec     (in_set_time && edit_dec && (i_pos == POS_HOUR)),
        .cin     (min_co),
        .clr     (1'b0),
        .q       (t_hour),
        .cout    (hour_co)
    );

    // Hour carry-out is exactly the HOUR_MAX:59:59 -> 00:00:00 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tick     <= 1'b0;
            o_day_wrap <= 1'b0;
        end else begin
            o_tick     <= tick_now;
            o_day_wrap <= hour_co;
        end
    end

    // Alarm registers: same counter, never advanced by carry.
    logic [SEC_W-1:0]        al_sec  [NUM_ALARMS];
    logic [SEC_W-1:0]        al_min  [NUM_ALARMS];
    logic [HOUR_W-1:0]       al_hour [NUM_ALARMS];
    logic [3*NUM_ALARMS-1:0] al_cout_unused;

    for (genvar a = 0; a < NUM_ALARMS; a++) begin : g_alarm
        logic sel_a;
        assign sel_a = in_set_alarm && (i_alarm_sel == 2'(a));

        hms_field #(.W(SEC_W)) u_al_sec (
            .clk     (clk),
            .rst     (rst),
            .max_val (SEC_MAX),
            .inc     (sel_a && edit_inc && (i_pos == POS_SEC)),
            .dec     (sel_a && edit_dec && (i_pos == POS_SEC)),
            .cin     (1'b0),
            .clr     (1'b0),
            .q       (al_sec[a]),
            .cout    (al_cout_unused[3*a])
        );

        hms_field #(.W(SEC_W)) u_al_min (
            .clk     (clk),
            .rst     (rst),
            .max_val (SEC_MAX),
            .inc     (sel_a && edit_inc && (i_pos == POS_MIN)),
            .dec     (sel_a && edit_dec && (i_pos == POS_MIN)),
            .cin     (1'b0),
            .clr     (1'b0),
            .q       (al_min[a]),
            .cout    (al_cout_unused[3*a+1])
        );

        hms_field #(.W(HOUR_W)) u_al_hour (
            .clk     (clk),
            .rst     (rst),
            .max_val (HOUR_TOP),
            .inc     (sel_a && edit_inc && (i_pos == POS_HOUR)),
            .dec     (sel_a && edit_dec && (i_pos == POS_HOUR)),
            .cin     (1'b0),
            .clr     (1'b0),
            .q       (al_hour[a]),
            .cout    (al_cout_unused[3*a+2])
        );
    end

    // Display mux; an out-of-range alarm select falls back to the time.
    always_comb begin
        o_sec  = t_sec;
        o_min  = t_min;
        o_hour = t_hour;
        if (in_set_alarm) begin
            for (int a = 0; a < NUM_ALARMS; a++) begin
                if (i_alarm_sel == 2'(a)) begin
                    o_sec  = al_sec[a];
                    o_min  = al_min[a];
                    o_hour = al_hour[a];
                end
            end
        end
    end

    // Alarm compare; scanning downward leaves the lowest matching index.
    logic       hit;
    logic [1:0] hit_id;

    always_comb begin
        hit    = 1'b0;
        hit_id = 2'd0;
        for (int a = NUM_ALARMS - 1; a >= 0; a--) begin
            if (i_alarm_en[a] && (t_sec == al_sec[a]) &&
                (t_min == al_min[a]) && (t_hour == al_hour[a])) begin
                hit    = 1'b1;
                hit_id = 2'(a);
            end
        end
    end

    logic ring_en;

    always_comb begin
        ring_en = 1'b0;
        for (int a = 0; a < NUM_ALARMS; a++) begin
            if (o_ring_id == 2'(a)) begin
                ring_en = i_alarm_en[a];
            end
        end
    end

    // Ring FSM. o_tick marks a time value produced by a tick, so manual
    // edits (which never raise o_tick) cannot start a ring.
    ring_state_t     ring_state;
    logic [RC_W-1:0] ring_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_state <= RING_IDLE;
            ring_cnt   <= '0;
            o_ring_id  <= 2'd0;
        end else begin
            case (ring_state)
                RING_IDLE: begin
                    if (o_tick && hit) begin
                        ring_state <= RING_ACTIVE;
                        ring_cnt   <= '0;
                        o_ring_id  <= hit_id;
                    end
                end
                RING_ACTIVE: begin
                    if (i_stop || !ring_en) begin
                        ring_state <= RING_IDLE;
                    end else if (tick_now) begin
                        if (ring_cnt == RC_W'(RING_SEC - 1)) begin
                            ring_state <= RING_IDLE;
                        end else begin
                            ring_cnt <= ring_cnt + RC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_ring = (ring_state == RING_ACTIVE);

endmodule

// File: tb/tb_hms_timekeeper.sv
// tb/tb_hms_timekeeper.sv - self-checking bench for hms_timekeeper
module tb_hms_timekeeper;

    localparam int CLK_HZ   = 4;
    localparam int HOUR_MAX = 23;
    localparam int NA       = 2;
    localparam int RING_SEC = 3;
    localparam int DAY      = (HOUR_MAX + 1) * 3600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [1:0]    pos = 2'd3;
    logic [1:0]    sel = 2'd0;
    logic          inc = 1'b0;
    logic          dec = 1'b0;
    logic          stop = 1'b0;
    logic [NA-1:0] en = '0;

    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;
    logic       o_day_wrap;
    logic       o_ring;
    logic [1:0] o_ring_id;

    always #5 clk = ~clk;

    hms_timekeeper #(
        .CLK_HZ     (CLK_HZ),
        .HOUR_MAX   (HOUR_MAX),
        .NUM_ALARMS (NA),
        .RING_SEC   (RING_SEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (mode),
        .i_pos       (pos),
        .i_alarm_sel (sel),
        .i_inc       (inc),
        .i_dec       (dec),
        .i_alarm_en  (en),
        .i_stop      (stop),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_tick      (o_tick),
        .o_day_wrap  (o_day_wrap),
        .o_ring      (o_ring),
        .o_ring_id   (o_ring_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time and alarms as seconds-of-day.
    int m_tod;
    int m_phase;
    int m_alarm [NA];
    int m_rt;
    int m_id;
    bit m_tick;
    bit m_wrap;
    bit m_ring;

    // Ring id only meaningful while ringing.
    logic [21:0] obs;
    assign obs = {o_hour, o_min, o_sec, o_tick, o_day_wrap, o_ring,
                  o_ring ? o_ring_id : 2'd0};

    function automatic int edit_tod(int t, int p, bit up);
        int h = t / 3600;
        int m = (t / 60) % 60;
        int s = t % 60;
        case (p)
            0: s = up ? (s + 1) % 60 : (s + 59) % 60;
            1: m = up ? (m + 1) % 60 : (m + 59) % 60;
            2: h = up ? (h + 1) % (HOUR_MAX + 1) : (h + HOUR_MAX) % (HOUR_MAX + 1);
            default: ;
        endcase
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [21:0] exp_vec();
        int d = (mode == 2'd2 && int'(sel) < NA) ? m_alarm[sel] : m_tod;
        return {5'(d / 3600), 6'((d / 60) % 60), 6'(d % 60),
                m_tick, m_wrap, m_ring, m_ring ? 2'(m_id) : 2'd0};
    endfunction

    task automatic model_edge();
        bit tk;
        bit found;
        if (rst) begin
            m_tod = 0; m_phase = 0; m_tick = 0; m_wrap = 0;
            m_ring = 0; m_id = 0; m_rt = 0;
            for (int a = 0; a < NA; a++) m_alarm[a] = 0;
            return;
        end
        tk = (mode != 2'd1) && (m_phase == CLK_HZ - 1);
        if (!m_ring) begin
            found = 0;
            if (m_tick) begin
                for (int a = 0; a < NA; a++) begin
                    if (!found && en[a] && m_alarm[a] == m_tod) begin
                        found = 1; m_ring = 1; m_id = a; m_rt = 0;
                    end
                end
            end
        end else if (stop || !en[m_id]) begin
            m_ring = 0;
        end else if (tk) begin
            m_rt++;
            if (m_rt == RING_SEC) m_ring = 0;
        end
        m_phase = (mode == 2'd1 || tk) ? 0 : m_phase + 1;
        m_wrap  = tk && (m_tod == DAY - 1);
        if (tk) m_tod = (m_tod + 1) % DAY;
        if (inc != dec && pos != 2'd3) begin
            if (mode == 2'd1) m_tod = edit_tod(m_tod, pos, inc);
            else if (mode == 2'd2 && int'(sel) < NA) m_alarm[sel] = edit_tod(m_alarm[sel], pos, inc);
        end
        m_tick = tk;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        inc = 0; dec = 0; stop = 0;
    endtask

    task automatic test_reset();
        rst = 1; mode = 0; pos = 3; en = '0;
        step(); step();
        checks++;
        if ({o_hour, o_min, o_sec, o_tick, o_day_wrap, o_ring, o_ring_id} !== 22'd0) begin
            errors++; $display("FAIL reset_state got %h exp 0", obs);
        end
        rst = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL run_after_reset c=%0d got %h exp %h", c, obs, exp_vec());
            end
            if (c == 4 || c == 8) begin
                checks++;
                if (o_tick !== 1'b1 || o_sec !== 6'(c / 4)) begin
                    errors++; $display("FAIL tick_cadence c=%0d got tick=%b sec=%0d exp tick=1 sec=%0d", c, o_tick, o_sec, c / 4);
                end
            end
        end
        rst = 1;
        step();
        checks++;
        if ({o_hour, o_min, o_sec, o_tick, o_day_wrap, o_ring, o_ring_id} !== 22'd0) begin
            errors++; $display("FAIL reset_mid_count got %h exp 0", obs);
        end
        rst = 0;
    endtask

    task automatic test_day_wrap();
        rst = 1; step(); rst = 0;
        mode = 1;
        pos = 0; dec = 1; step();
        pos = 1; dec = 1; step();
        pos = 2; dec = 1; step();
        checks++;
        if ({o_hour, o_min, o_sec} !== {5'd23, 6'd59, 6'd59} || obs !== exp_vec()) begin
            errors++; $display("FAIL load_235959 got %0d:%0d:%0d exp 23:59:59", o_hour, o_min, o_sec);
        end
        mode = 0; pos = 3;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL day_wrap_run c=%0d got %h exp %h", c, obs, exp_vec());
            end
            if (c == 4) begin
                checks++;
                if ({o_hour, o_min, o_sec} !== 17'd0 || o_tick !== 1'b1 || o_day_wrap !== 1'b1) begin
                    errors++; $display("FAIL day_wrap_edge got %0d:%0d:%0d tick=%b wrap=%b exp 0:0:0 tick=1 wrap=1", o_hour, o_min, o_sec, o_tick, o_day_wrap);
                end
            end
            if (c == 5) begin
                checks++;
                if (o_day_wrap !== 1'b0 || o_tick !== 1'b0) begin
                    errors++; $display("FAIL day_wrap_width got tick=%b wrap=%b exp 0 0", o_tick, o_day_wrap);
                end
            end
        end
    endtask

    task automatic test_set_time_edges();
        rst = 1; step(); rst = 0;
        mode = 1; pos = 1; dec = 1; step();
        checks++;
        if ({o_hour, o_min, o_sec} !== {5'd0, 6'd59, 6'd0}) begin
            errors++; $display("FAIL min_dec_wrap got %0d:%0d:%0d exp 0:59:0", o_hour, o_min, o_sec);
        end
        inc = 1; dec = 1; step();
        checks++;
        if ({o_hour, o_min, o_sec} !== {5'd0, 6'd59, 6'd0}) begin
            errors++; $display("FAIL inc_dec_together got %0d:%0d:%0d exp 0:59:0", o_hour, o_min, o_sec);
        end
        pos = 3; inc = 1; step();
        checks++;
        if (obs !== exp_vec() || o_min !== 6'd59) begin
            errors++; $display("FAIL pos_none got %h exp %h", obs, exp_vec());
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (o_tick !== 1'b0 || obs !== exp_vec()) begin
                errors++; $display("FAIL no_tick_in_set c=%0d got %h exp %h", c, obs, exp_vec());
            end
        end
        mode = 0;
    endtask

    task automatic test_alarm_ring();
        bit found;
        rst = 1; step(); rst = 0;
        en = 2'b11; mode = 2; pos = 0;
        for (int a = 0; a < NA; a++) begin
            sel = 2'(a);
            for (int k = 0; k < 5; k++) begin
                inc = 1; step();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL alarm_edit a=%0d got %h exp %h", a, obs, exp_vec());
                end
            end
        end
        mode = 0; pos = 3;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL alarm_wait got %h exp %h", obs, exp_vec());
            end
            if (o_sec == 6'd5) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL wait_sec5 got sec=%0d exp 5", o_sec);
        end
        step();
        checks++;
        if (o_ring !== 1'b1 || o_ring_id !== 2'd0) begin
            errors++; $display("FAIL ring_rise got ring=%b id=%0d exp ring=1 id=0", o_ring, o_ring_id);
        end
        stop = 1; step();
        checks++;
        if (o_ring !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL ring_stop got ring=%b exp 0", o_ring);
        end
    endtask

    task automatic arm_alarm0_at3();
        rst = 1; step(); rst = 0;
        en = 2'b01; mode = 2; sel = 0; pos = 0;
        for (int k = 0; k < 3; k++) begin
            inc = 1; step();
        end
        mode = 0; pos = 3;
    endtask

    task automatic test_ring_timeout();
        bit found;
        int ticks;
        arm_alarm0_at3();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL timeout_wait got %h exp %h", obs, exp_vec());
            end
            if (o_ring) found = 1;
        end
        checks++;
        if (!found || o_sec !== 6'd3) begin
            errors++; $display("FAIL timeout_rise got ring=%b sec=%0d exp ring=1 sec=3", o_ring, o_sec);
        end
        ticks = 0;
        for (int c = 0; c < 30 && o_ring; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL timeout_run got %h exp %h", obs, exp_vec());
            end
            if (o_tick) ticks++;
        end
        checks++;
        if (o_ring !== 1'b0 || ticks != RING_SEC || o_tick !== 1'b1) begin
            errors++; $display("FAIL ring_timeout got ring=%b ticks=%0d tick=%b exp ring=0 ticks=%0d tick=1", o_ring, ticks, o_tick, RING_SEC);
        end
        arm_alarm0_at3();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (o_ring) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL en_drop_rise got ring=%b exp 1", o_ring);
        end
        en = 2'b00; step();
        checks++;
        if (o_ring !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL en_drop got ring=%b exp 0", o_ring);
        end
    endtask

    task automatic test_manual_no_ring();
        rst = 1; step(); rst = 0;
        en = 2'b01; mode = 2; sel = 0; pos = 0;
        for (int k = 0; k < 10; k++) begin
            inc = 1; step();
        end
        mode = 1; pos = 0;
        for (int k = 0; k < 60 && (m_tod % 60) != 10; k++) begin
            inc = 1; step();
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (o_ring !== 1'b0 || o_sec !== 6'd10) begin
                errors++; $display("FAIL manual_no_ring got ring=%b sec=%0d exp ring=0 sec=10", o_ring, o_sec);
            end
        end
        dec = 1; step();
        mode = 0; pos = 3;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL run_to_alarm got %h exp %h", obs, exp_vec());
            end
        end
        step();
        checks++;
        if (o_ring !== 1'b1 || o_ring_id !== 2'd0 || o_sec !== 6'd10) begin
            errors++; $display("FAIL ring_after_tick got ring=%b id=%0d sec=%0d exp 1 0 10", o_ring, o_ring_id, o_sec);
        end
        stop = 1; step();
    endtask

    task automatic test_random();
        rst = 1; step(); rst = 0;
        mode = 0; en = 2'b11;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            pos  = 2'($urandom_range(0, 3));
            sel  = 2'($urandom_range(0, 3));
            inc  = ($urandom_range(0, 3) == 0);
            dec  = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) en = NA'($urandom);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d mode=%0d got %h exp %h", c, mode, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_day_wrap();
        test_set_time_edges();
        test_alarm_ring();
        test_ring_timeout();
        test_manual_no_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hms_timekeeper.md
# hms_timekeeper

Parametrised HH:MM:SS timekeeping core with N independent alarms. It is the successor to the gated-clock min/sec counter. All counting runs on the single system clock, using a 1 Hz tick enable and pulse-style set controls. The core sits between the debounced/edge-detected switch logic and the display path (digit separation, segment decode, digit multiplexing), and drives the buzzer enable.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock cycles per second; must be ≥2.
- HOUR_MAX, 23, hour wrap value (11 or 23).
- NUM_ALARMS, 2, number of alarm channels (1..4).
- RING_SEC, 60, maximum ring duration in seconds before auto-stop (≥1).

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- i_mode  in  2  0=CLOCK, 1=SET_TIME, 2=SET_ALARM, 3=reserved (behaves as CLOCK).
- i_pos  in  2  field select: 0=sec, 1=min, 2=hour, 3=none.
- i_alarm_sel  in  2  alarm index edited/displayed in SET_ALARM; values ≥NUM_ALARMS are ignored.
- i_inc  in  1  single-cycle increment pulse for the selected field.
- i_dec  in  1  single-cycle decrement pulse for the selected field.
- i_alarm_en  in  NUM_ALARMS  per-alarm enable level.
- i_stop  in  1  single-cycle ring acknowledge.
- o_sec  out  6  displayed seconds.
- o_min  out  6  displayed minutes.
- o_hour  out  5  displayed hours.
- o_tick  out  1  one-cycle pulse on each time advance.
- o_day_wrap  out  1  one-cycle pulse when time wraps HOUR_MAX:59:59 → 00:00:00.
- o_ring  out  1  alarm ringing; feeds the buzzer enable.
- o_ring_id  out  2  index of the ringing alarm; valid while o_ring=1.

## Operation
- Prescaler counts 0..CLK_HZ-1. At terminal count: prescaler→0, o_tick=1, and time advances by one second with carry sec→min→hour.
- SET_TIME:
  - Prescaler is held at 0 and there are no ticks.
  - i_inc/i_dec modify only the selected time field. Increment wraps max→0 and decrement wraps 0→max, with no carry into other fields.
  - Leaving SET_TIME starts a full CLK_HZ-cycle second.
- SET_ALARM:
  - The clock keeps running.
  - i_inc/i_dec edit the selected field of alarm i_alarm_sel.
  - Display outputs show that alarm's h:m:s.
- CLOCK/reserved mode: i_inc/i_dec are ignored.
- i_pos=3 makes i_inc/i_dec no-ops. i_inc and i_dec in the same cycle produce no change.
- Alarm match is evaluated only on tick-driven time updates. Manual setting of the time or an alarm never triggers a ring.
- Ring FSM states are IDLE and RING.
- IDLE→RING when a tick produces a time equal to an enabled alarm. When several alarms match, the lowest index wins and is latched into o_ring_id.
- RING→IDLE on any of:
  - i_stop;
  - deassertion of i_alarm_en[o_ring_id];
  - RING_SEC ticks counted inside RING.
- A new match while in RING is ignored; no re-trigger.
- Reset values: all time/alarm registers 0, prescaler 0, o_tick=0, o_day_wrap=0, o_ring=0, o_ring_id=0, FSM=IDLE. Reset mid-ring returns to IDLE on the next edge.

## Timing
- o_tick, o_day_wrap and the new time values become visible together, on the edge where the prescaler is at terminal count.
- The first tick after reset deassertion occurs CLK_HZ cycles later.
- Field edit: the value changes on the edge that samples the i_inc/i_dec pulse, a 1-cycle latency.
- o_ring rises one cycle after the matching time is visible (registered compare).
- o_ring falls on the edge after i_stop or after the enable drops.
- On timeout, o_ring falls on the edge of the RING_SEC-th tick.
- All outputs are registered except the display mux, which is combinational on registered values and i_mode/i_alarm_sel.

## Structure
- Shared package hms_pkg holds:
  - mode encodings (MODE_CLOCK/SET_TIME/SET_ALARM);
  - field encodings (POS_SEC/MIN/HOUR/NONE);
  - field widths (SEC_W=6, HOUR_W=5);
  - ring FSM state type.
- One sub-module, hms_field: a wrap counter with max input and inc/dec/carry-in/load-zero inputs and carry-out. Instantiate it for sec/min/hour and, via generate, for each alarm's three fields (alarm instances with carry-in tied low).

## Test plan
- CLK_HZ=4, release rst: o_tick pulses every 4 cycles, o_sec steps 0→1→2. Assert rst mid-count: all outputs return to 0 on the next edge.
- SET_TIME: load 23:59:59 via dec pulses, then switch to CLOCK: the 4th cycle shows 00:00:00 with o_tick=1 and o_day_wrap=1 for exactly one cycle.
- SET_TIME, pos=min, min=0: dec→59 with hour unchanged; inc and dec together → no change; no o_tick is seen during SET_TIME.
- Alarms 0 and 1 both set to 00:00:05 and enabled: o_ring=1 one cycle after o_sec=5, o_ring_id=0; i_stop pulse clears o_ring on the next edge.
- RING_SEC=3, no stop: o_ring drops on the 3rd tick after rising; clearing i_alarm_en[0] in a separate run drops o_ring on the next edge.
- Alarm 0 = 00:00:10 enabled; set time manually to 00:00:10 in SET_TIME: no ring. Set it to 00:00:09 and run: ring after the next tick.
